// File: rtl/n101_tl_qspi_arbiter_pkg.sv
// Shared definitions for the 2:1 TileLink arbiter in front of the QSPI width adapter:
// TL opcodes, field widths, FSM encoding and the outstanding-counter update helper.
package n101_tl_qspi_arbiter_pkg;

    // TL-UL opcodes
    localparam logic [2:0] TlGet              = 3'd4;
    localparam logic [2:0] TlPutFull          = 3'd0;
    localparam logic [2:0] TlPutPartial       = 3'd1;
    localparam logic [2:0] TlAccessAck        = 3'd0;
    localparam logic [2:0] TlAccessAckData    = 3'd1;

    // Field widths
    localparam int unsigned AddrWidth = 30;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned MaskWidth = 4;
    localparam int unsigned SrcWidth  = 2;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } arb_state_e;

    // Saturating up/down count; simultaneous inc and dec cancel out.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic inc,
                                            input logic dec, input logic [1:0] max_cnt);
        cnt_next = cnt;
        if (inc && !dec && (cnt < max_cnt)) begin
            cnt_next = cnt + 2'd1;
        end else if (dec && !inc && (cnt != 2'd0)) begin
            cnt_next = cnt - 2'd1;
        end
    endfunction

endpackage

// File: rtl/n101_tl_qspi_arbiter_rr_pick2.sv
// Two-way request picker; ptr_i selects the winner when both request.
module n101_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       gnt_o,
    output logic       any_o
);

    // Winner index: sole requester, or the pointer master on a tie
    always_comb begin
        any_o = |req_i;
        gnt_o = 1'b0;
        unique case (req_i)
            2'b11:   gnt_o = ptr_i;
            2'b10:   gnt_o = 1'b1;
            default: gnt_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/n101_tl_qspi_arbiter.sv
// 2:1 TileLink-UL A-channel arbiter with D-channel return routing, feeding the QSPI
// width adapter. Optional build macro: N101_QSPI_ARB_RR_EN selects round-robin ties;
// without it m0 always wins ties.
module n101_tl_qspi_arbiter
    import n101_tl_qspi_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    // master 0 A
    input  logic                 m0_a_valid,
    output logic                 m0_a_ready,
    input  logic [2:0]           m0_a_bits_opcode,
    input  logic [2:0]           m0_a_bits_param,
    input  logic [2:0]           m0_a_bits_size,
    input  logic [SrcWidth-1:0]  m0_a_bits_source,
    input  logic [AddrWidth-1:0] m0_a_bits_address,
    input  logic [MaskWidth-1:0] m0_a_bits_mask,
    input  logic [DataWidth-1:0] m0_a_bits_data,
    // master 0 D
    output logic                 m0_d_valid,
    input  logic                 m0_d_ready,
    output logic [2:0]           m0_d_bits_opcode,
    output logic [1:0]           m0_d_bits_param,
    output logic [2:0]           m0_d_bits_size,
    output logic [SrcWidth-1:0]  m0_d_bits_source,
    output logic [DataWidth-1:0] m0_d_bits_data,
    output logic                 m0_d_bits_error,
    // master 1 A
    input  logic                 m1_a_valid,
    output logic                 m1_a_ready,
    input  logic [2:0]           m1_a_bits_opcode,
    input  logic [2:0]           m1_a_bits_param,
    input  logic [2:0]           m1_a_bits_size,
    input  logic [SrcWidth-1:0]  m1_a_bits_source,
    input  logic [AddrWidth-1:0] m1_a_bits_address,
    input  logic [MaskWidth-1:0] m1_a_bits_mask,
    input  logic [DataWidth-1:0] m1_a_bits_data,
    // master 1 D
    output logic                 m1_d_valid,
    input  logic                 m1_d_ready,
    output logic [2:0]           m1_d_bits_opcode,
    output logic [1:0]           m1_d_bits_param,
    output logic [2:0]           m1_d_bits_size,
    output logic [SrcWidth-1:0]  m1_d_bits_source,
    output logic [DataWidth-1:0] m1_d_bits_data,
    output logic                 m1_d_bits_error,
    // downstream A
    output logic                 out_a_valid,
    input  logic                 out_a_ready,
    output logic [2:0]           out_a_bits_opcode,
    output logic [2:0]           out_a_bits_param,
    output logic [2:0]           out_a_bits_size,
    output logic [SrcWidth:0]    out_a_bits_source,
    output logic [AddrWidth-1:0] out_a_bits_address,
    output logic [MaskWidth-1:0] out_a_bits_mask,
    output logic [DataWidth-1:0] out_a_bits_data,
    // downstream D
    input  logic                 out_d_valid,
    output logic                 out_d_ready,
    input  logic [2:0]           out_d_bits_opcode,
    input  logic [1:0]           out_d_bits_param,
    input  logic [2:0]           out_d_bits_size,
    input  logic [SrcWidth:0]    out_d_bits_source,
    input  logic [DataWidth-1:0] out_d_bits_data,
    input  logic                 out_d_bits_error
);

    localparam logic [1:0] MaxOut = 2'(MAX_OUT);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic [1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic       elig0, elig1;
    logic       pick, pick_any, ptr, grant;
    logic       a_fire, a_fire0, a_fire1, d_fire0, d_fire1;

    assign elig0 = m0_a_valid && (cnt0_q < MaxOut);
    assign elig1 = m1_a_valid && (cnt1_q < MaxOut);

    n101_rr_pick2 u_pick (
        .req_i ({elig1, elig0}),
        .ptr_i (ptr),
        .gnt_o (pick),
        .any_o (pick_any)
    );

`ifdef N101_QSPI_ARB_RR_EN
    logic ptr_q, ptr_d;

    // Round-robin pointer register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

    // After each downstream fire, prefer the master that did not just win
    always_comb begin
        ptr_d = ptr_q;
        if (a_fire) ptr_d = ~grant;
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    // FSM state, latched grant and outstanding counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            cnt0_q  <= 2'd0;
            cnt1_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    // Next state: a stalled grant is frozen until the downstream accepts it
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (out_a_valid && !out_a_ready) begin
                    state_d = StHold;
                    grant_d = grant;
                end
            end
            StHold: begin
                if (out_a_valid && out_a_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: combinational grant in IDLE, latched grant in HOLD
    always_comb begin
        grant       = pick;
        out_a_valid = pick_any;
        if (state_q == StHold) begin
            grant       = grant_q;
            out_a_valid = 1'b1;
        end
        m0_a_ready         = out_a_ready && !grant && elig0;
        m1_a_ready         = out_a_ready &&  grant && elig1;
        out_a_bits_opcode  = grant ? m1_a_bits_opcode  : m0_a_bits_opcode;
        out_a_bits_param   = grant ? m1_a_bits_param   : m0_a_bits_param;
        out_a_bits_size    = grant ? m1_a_bits_size    : m0_a_bits_size;
        out_a_bits_source  = {grant, (grant ? m1_a_bits_source : m0_a_bits_source)};
        out_a_bits_address = grant ? m1_a_bits_address : m0_a_bits_address;
        out_a_bits_mask    = grant ? m1_a_bits_mask    : m0_a_bits_mask;
        out_a_bits_data    = grant ? m1_a_bits_data    : m0_a_bits_data;
    end

    assign a_fire  = out_a_valid && out_a_ready;
    assign a_fire0 = m0_a_valid && m0_a_ready;
    assign a_fire1 = m1_a_valid && m1_a_ready;
    assign d_fire0 = m0_d_valid && m0_d_ready;
    assign d_fire1 = m1_d_valid && m1_d_ready;

    // Outstanding counters per master
    always_comb begin
        cnt0_d = cnt_next(cnt0_q, a_fire0, d_fire0, MaxOut);
        cnt1_d = cnt_next(cnt1_q, a_fire1, d_fire1, MaxOut);
    end

    // D path: steer by source MSB, independent of A-channel state
    assign m0_d_valid       = out_d_valid && !out_d_bits_source[SrcWidth];
    assign m1_d_valid       = out_d_valid &&  out_d_bits_source[SrcWidth];
    assign out_d_ready      = out_d_bits_source[SrcWidth] ? m1_d_ready : m0_d_ready;
    assign m0_d_bits_opcode = out_d_bits_opcode;
    assign m0_d_bits_param  = out_d_bits_param;
    assign m0_d_bits_size   = out_d_bits_size;
    assign m0_d_bits_source = out_d_bits_source[SrcWidth-1:0];
    assign m0_d_bits_data   = out_d_bits_data;
    assign m0_d_bits_error  = out_d_bits_error;
    assign m1_d_bits_opcode = out_d_bits_opcode;
    assign m1_d_bits_param  = out_d_bits_param;
    assign m1_d_bits_size   = out_d_bits_size;
    assign m1_d_bits_source = out_d_bits_source[SrcWidth-1:0];
    assign m1_d_bits_data   = out_d_bits_data;
    assign m1_d_bits_error  = out_d_bits_error;

endmodule

// File: doc/n101_tl_qspi_arbiter.md
N101_TL_QSPI_ARBITER -- requirements
Module: n101_tl_qspi_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUT, default 2, the maximum outstanding A-requests per master (range 1..3).
REQ-002 SHALL have input `clock`, 1 bit, the only clock.
REQ-003 SHALL have input `reset`, 1 bit, asynchronous, active-high.
REQ-004 SHALL have, for each master k in {0,1}, input `mk_a_valid` (1 bit) and output `mk_a_ready` (1 bit).
REQ-005 SHALL have, for each k, inputs `mk_a_bits_{opcode,param,size}` (3 bits each), `mk_a_bits_source` (2), `mk_a_bits_address` (30), `mk_a_bits_mask` (4) and `mk_a_bits_data` (32).
REQ-006 SHALL have, for each k, outputs `mk_d_valid` (1), `mk_d_bits_{opcode,size}` (3 each), `mk_d_bits_param` (2), `mk_d_bits_source` (2), `mk_d_bits_data` (32) and `mk_d_bits_error` (1), plus input `mk_d_ready` (1).
REQ-007 SHALL have outputs `out_a_valid` (1), `out_a_bits_{opcode,param,size}` (3 each), `out_a_bits_source` (3), `out_a_bits_address` (30), `out_a_bits_mask` (4), `out_a_bits_data` (32), and input `out_a_ready` (1); this port feeds the 32-to-8 QSPI width adapter.
REQ-008 SHALL have inputs `out_d_valid` (1), `out_d_bits_{opcode,size}` (3 each), `out_d_bits_param` (2), `out_d_bits_source` (3), `out_d_bits_data` (32), `out_d_bits_error` (1), and output `out_d_ready` (1).

Function
REQ-009 SHALL form `out_a_bits_source` as {master id, master source}, with bit 2 = 1 for m1.
REQ-010 SHALL implement FSM states IDLE and HOLD.
REQ-011 In IDLE, SHALL grant one eligible valid master combinationally in the same cycle, with zero added latency.
REQ-012 A master SHALL be eligible only if `mk_a_valid` = 1 and its outstanding count is below MAX_OUT.
REQ-013 IDLE→HOLD SHALL occur when `out_a_valid` = 1 and `out_a_ready` = 0, latching the grant.
REQ-014 HOLD→IDLE SHALL occur on `out_a_ready` & `out_a_valid`; in HOLD, grant, `out_a_valid` and `out_a_bits` SHALL stay stable and no re-arbitration SHALL occur.
REQ-015 `mk_a_ready` SHALL equal `out_a_ready` & (grant == k) & eligible(k); a non-granted master SHALL see ready = 0.
REQ-016 SHALL keep a per-master 2-bit outstanding counter: +1 on that master's A fire, -1 on its D fire (`mk_d_valid` & `mk_d_ready`).
REQ-017 When increment and decrement hit the same counter in the same cycle, the count SHALL be unchanged.
REQ-018 A counter SHALL never wrap past MAX_OUT or below 0; a D response arriving with count 0 SHALL be routed but SHALL leave the count at 0.
REQ-019 D SHALL route by `out_d_bits_source[2]`: only the selected master sees `mk_d_valid` = `out_d_valid`, and `out_d_ready` = the selected `mk_d_ready`.
REQ-020 `mk_d_bits_source` SHALL be `out_d_bits_source[1:0]`; the other D fields SHALL pass through unchanged to both masters.
REQ-021 The D path SHALL be purely combinational, and D SHALL never be blocked by A-channel state.

Reset
REQ-022 Reset SHALL put the FSM in IDLE, both counters at 0, the round-robin pointer at 0 (m0 preferred first), and the latched grant at 0.
REQ-023 After reset, all valid/ready outputs SHALL follow the combinational rules above (`out_a_valid` = 0 with no master valid).
REQ-024 Reset asserted mid-transfer SHALL drop HOLD and discard outstanding counts immediately; no response replay is required.

Configuration
REQ-025 With macro N101_QSPI_ARB_RR_EN defined, arbitration SHALL be round-robin: the pointer moves to the other master after each A fire and the pointer master wins ties.
REQ-026 Without N101_QSPI_ARB_RR_EN, m0 SHALL always win ties (fixed priority), and the pointer SHALL be absent.

Structure
REQ-027 A shared package SHALL hold: TL opcode constants (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1), field widths (address 30, data 32, mask 4, source 2), and the FSM state encoding.
REQ-028 SHALL contain one sub-module, n101_rr_pick2 (2-way picker with tie-break pointer input), used in both configurations with the pointer tied to 0 when RR is disabled.

Verification
REQ-029 Both masters assert Get in the same cycle with `out_a_ready` = 1 (RR build) -> cycle 1 grants m0 with out source = 3'b0xx; cycle 2 grants m1 with out source = 3'b1xx.
REQ-030 m1 Get held while `out_a_ready` = 0 for 3 cycles, m0 asserts in cycle 2 -> the grant stays m1 with address/data stable and `m0_a_ready` = 0; m1 fires in cycle 4 and m0 fires in cycle 5.
REQ-031 MAX_OUT = 2, m0 issues two Gets with no D -> m0 becomes ineligible; m1 is still granted; after one D with source 3'b000, m0 becomes eligible the next cycle.
REQ-032 Same-cycle m0 A fire and m0 D fire at count 1 -> the count stays 1.
REQ-033 D response source 3'b110, data 32'hA5A5_0F0F, with `m1_d_ready` = 0 -> `m1_d_valid` = 1, `m0_d_valid` = 0, `out_d_ready` = 0; after ready, `m1_d_bits_source` = 2'b10.
REQ-034 Async reset pulsed while in HOLD with count 2 -> IDLE, counts 0, and `out_a_valid` follows inputs in the same cycle reset deasserts.
